// File: rtl/sar_search_8_bit_if.sv
// sar_search_8_bit_if: start/compare/result bundle between the search controller and its comparator side
interface sar_search_8_bit_if #(parameter int DATA_WIDTH = 8);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] trial_o;
    logic                  trial_valid_o;
    logic                  cmp_valid_i;
    logic                  cmp_greater_i;
    logic                  cmp_lower_i;
    logic                  cmp_equal_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  found_o;
    logic                  error_o;
    modport master (
        input  start_i, cmp_valid_i, cmp_greater_i, cmp_lower_i, cmp_equal_i,
        output trial_o, trial_valid_o, busy_o, done_o, result_o, found_o, error_o
    );
    modport slave (
        output start_i, cmp_valid_i, cmp_greater_i, cmp_lower_i, cmp_equal_i,
        input  trial_o, trial_valid_o, busy_o, done_o, result_o, found_o, error_o
    );
endinterface

// File: rtl/sar_search_8_bit.sv
// sar_search_8_bit: successive-approximation controller driving a magnitude comparator to find its target
module sar_search_8_bit #(
    parameter int DATA_WIDTH = 8
) (
    input logic                clk_i,
    input logic                rst_n_i,
    sar_search_8_bit_if.master bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_accum, r_trial, r_result, w_accum_nxt, w_bit_mask;
    logic [BW-1:0]         r_bit;
    logic                  r_found, r_error, w_hs, w_legal, w_last;
    always_comb begin
        w_bit_mask  = DATA_WIDTH'(1) << r_bit;
        w_hs        = (r_state == DRIVE) && bus.cmp_valid_i;
        w_legal     = $onehot({bus.cmp_greater_i, bus.cmp_lower_i, bus.cmp_equal_i});
        w_last      = r_bit == '0;
        w_accum_nxt = bus.cmp_lower_i ? (r_accum | w_bit_mask) : r_accum;
    end
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.start_i) w_state_nxt = DRIVE;
            DRIVE:   if (w_hs && (!w_legal || bus.cmp_equal_i || w_last)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_accum  <= '0;
            r_trial  <= '0;
            r_result <= '0;
            r_bit    <= BW'(DATA_WIDTH - 1);
            r_found  <= 1'b0;
            r_error  <= 1'b0;
        end else if (r_state == IDLE && bus.start_i) begin
            r_accum  <= '0;
            r_trial  <= DATA_WIDTH'(1) << (DATA_WIDTH - 1);
            r_result <= '0;
            r_bit    <= BW'(DATA_WIDTH - 1);
            r_found  <= 1'b0;
            r_error  <= 1'b0;
        end else if (w_hs) begin
            if (!w_legal) begin
                r_error  <= 1'b1;
                r_result <= '0;
            end else if (bus.cmp_equal_i) begin
                r_accum  <= r_trial;
                r_result <= r_trial;
                r_found  <= 1'b1;
            end else begin
                r_accum <= w_accum_nxt;
                // the next trial is registered now so it is presented the cycle after this handshake
                if (w_last) r_result <= w_accum_nxt;
                else begin
                    r_bit   <= r_bit - 1'b1;
                    r_trial <= w_accum_nxt | (w_bit_mask >> 1);
                end
            end
        end
    end
    assign bus.trial_o       = r_trial;
    assign bus.trial_valid_o = r_state == DRIVE;
    assign bus.busy_o        = r_state != IDLE;
    assign bus.done_o        = r_state == DONE;
    assign bus.result_o      = r_result;
    assign bus.found_o       = r_found;
    assign bus.error_o       = r_error;
endmodule
